microc_ctrl_fsm: RTL
====================

Name: microc_ctrl_fsm

Overview:
Multi-cycle control unit for the microc datapath. It decodes the 6-bit Opcode and the z flag returned by the datapath. It drives the datapath control inputs s_inc, s_inm, we3, wez and Op, plus a PC load enable pc_en; the microc PC register loads only when pc_en=1. Each instruction takes two cycles (FETCH, EXEC), with run, single-step and halt control and a retired-instruction counter.

Parameters:
CNT_W, 16, width of instr_cnt
START_ON_RESET, 0, 1: leave reset directly into FETCH without waiting for start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution from IDLE
step_mode  input  1  1: return to IDLE after each instruction
step  input  1  in step mode, execute one instruction from IDLE
Opcode  input  6  instruction bits [15:10] from datapath
z  input  1  registered zero flag from datapath
s_inc  output  1  1: next PC = PC+1; 0: next PC = jump target
s_inm  output  1  1: register write data = immediate
we3  output  1  register file write enable
wez  output  1  zero-flag write enable
Op  output  3  ALU operation
pc_en  output  1  PC register load enable
busy  output  1  state is FETCH or EXEC
halted  output  1  state is HALT
illegal  output  1  sticky illegal-opcode indication
instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Opcode map:
  - 00xxxx LI: s_inm=1, we3=1, wez=0, s_inc=1.
  - 01oooX ALU: Op=Opcode[3:1], s_inm=0, we3=1, wez=1, s_inc=1.
  - 100000 J: s_inc=0.
  - 100001 JZ: s_inc=~z.
  - 100010 JNZ: s_inc=z.
  - 111111 HALT.
  - All other 10xxxx/11xxxx opcodes are unrecognised.
- States: IDLE, FETCH, EXEC, HALT.
- Reset:
  - State goes to IDLE, or FETCH if START_ON_RESET=1.
  - instr_cnt=0, illegal=0.
  - All strobes (we3, wez, pc_en) are forced 0 combinationally while reset=1, including a reset cycle landing in EXEC. No register, flag or PC update occurs in that cycle.
- Default outputs (IDLE, FETCH, HALT): s_inc=1, s_inm=0, we3=0, wez=0, Op=000, pc_en=0.
- IDLE:
  - Go to FETCH when start=1, or when step_mode=1 and step=1.
  - Otherwise stay in IDLE.
- FETCH:
  - One cycle for instruction ROM settling; always go to EXEC.
  - start and step are ignored.
- EXEC:
  - Outputs are decoded from Opcode and z in the same cycle. The datapath commits on the clock edge at the end of EXEC.
  - For every opcode except HALT: pc_en=1.
  - For LI/ALU/J/JZ/JNZ: instr_cnt increments by 1, wrapping modulo 2^CNT_W.
  - HALT opcode: pc_en=0, no writes, instr_cnt unchanged, next state HALT.
  - Otherwise: next state IDLE if step_mode=1 (sampled in EXEC), else FETCH.
- JZ/JNZ use z as registered at the end of the previous EXEC, so a branch immediately after an ALU instruction sees that instruction's result.
- HALT: halted=1; only reset exits. start and step are ignored.
- busy=1 exactly in FETCH and EXEC; halted=1 exactly in HALT. busy and halted are never both 1.
- Throughput: with step_mode=0, one instruction every 2 cycles.
- Unrecognised opcode: handled per the optional feature below.

Optional Feature:
MICROC_CTRL_ILLEGAL_TRAP_EN
- Defined: an unrecognised opcode in EXEC behaves like HALT (pc_en=0, no writes, no count increment). State goes to HALT and illegal is set to 1 on the same edge. illegal stays 1 until reset.
- Undefined:
  - An unrecognised opcode executes as NOP: pc_en=1, s_inc=1, no writes, instr_cnt increments.
  - illegal is tied to 0.

Test Plan:
1. Reset, start=1 for one cycle, Opcode=000101 (LI):
   - FETCH: pc_en=0, we3=0.
   - EXEC: s_inm=1, we3=1, wez=0, s_inc=1, pc_en=1.
   - instr_cnt goes 0->1; next state FETCH.
2. Opcode=010100 (ALU, Op=010):
   - EXEC: Op=3'b010, we3=1, wez=1, s_inm=0, pc_en=1.
   - Opcode=011110 -> Op=3'b111.
3. JZ branch on z:
   - Opcode=100001, z=1: EXEC s_inc=0, pc_en=1.
   - Repeat with z=0: s_inc=1.
   - JNZ (100010) gives the inverse results.
4. Opcode=111111 (HALT):
   - EXEC: pc_en=0, we3=0, instr_cnt unchanged.
   - Next cycle: halted=1, busy=0.
   - Pulsing start/step leaves state in HALT.
   - reset=1 for one cycle -> IDLE, instr_cnt=0.
5. Single step, step_mode=1, start pulse:
   - One FETCH/EXEC pair, then IDLE with busy=0.
   - No further pc_en until a step pulse.
   - With CNT_W=2, four instructions wrap instr_cnt to 0.
6. Opcode=110000 and mid-EXEC reset:
   - With MICROC_CTRL_ILLEGAL_TRAP_EN: HALT, illegal=1, pc_en=0.
   - Without it: NOP, pc_en=1, s_inc=1, illegal=0, count +1.
   - Asserting reset during an EXEC: we3=wez=pc_en=0 in that cycle.

Source files
------------

// File: rtl/microc_ctrl_fsm.sv
// Two-cycle (FETCH/EXEC) control unit for the microc datapath, with run/step/halt control and a retired-instruction counter.
// Optional illegal-opcode trap is enabled by defining MICROC_CTRL_ILLEGAL_TRAP_EN.
module microc_ctrl_fsm #(
    parameter int CNT_W          = 16,
    parameter bit START_ON_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_is_li;
    logic w_is_alu;
    logic w_is_j;
    logic w_is_jz;
    logic w_is_jnz;
    logic w_is_halt;
    logic w_stop;

    assign w_is_li   = (Opcode[5:4] == 2'b00);
    assign w_is_alu  = (Opcode[5:4] == 2'b01);
    assign w_is_j    = (Opcode == 6'b100000);
    assign w_is_jz   = (Opcode == 6'b100001);
    assign w_is_jnz  = (Opcode == 6'b100010);
    assign w_is_halt = (Opcode == 6'b111111);

`ifdef MICROC_CTRL_ILLEGAL_TRAP_EN
    logic w_unrec;
    logic r_illegal;

    assign w_unrec = ~(w_is_li | w_is_alu | w_is_j | w_is_jz | w_is_jnz | w_is_halt);
    assign w_stop  = w_is_halt | w_unrec;
    assign illegal = r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_EXEC && w_unrec) begin
            r_illegal <= 1'b1;
        end
    end
`else
    // Unrecognised opcodes fall through the decode below and act as NOP.
    assign w_stop  = w_is_halt;
    assign illegal = 1'b0;
`endif

    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        pc_en = 1'b0;
        if (r_state == S_EXEC && !w_stop) begin
            pc_en = 1'b1;
            if (w_is_li) begin
                s_inm = 1'b1;
                we3   = 1'b1;
            end else if (w_is_alu) begin
                Op  = Opcode[3:1];
                we3 = 1'b1;
                wez = 1'b1;
            end else if (w_is_j) begin
                s_inc = 1'b0;
            end else if (w_is_jz) begin
                s_inc = ~z;
            end else if (w_is_jnz) begin
                s_inc = z;
            end
        end
        // A reset cycle must never commit anything into the datapath.
        if (reset) begin
            we3   = 1'b0;
            wez   = 1'b0;
            pc_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= START_ON_RESET ? S_FETCH : S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start || (step_mode && step)) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_stop) begin
                        r_state <= S_HALT;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_state <= step_mode ? S_IDLE : S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign halted    = (r_state == S_HALT);
    assign instr_cnt = r_cnt;

endmodule
